// File: rtl/debounce_tick_array.sv
// debounce_tick_array: multi-channel push-button conditioner.
// Each channel has a 2-flop synchroniser and a stability debounce that drives
// the debounced level stater. It also has a one-cycle tick on press or on
// release, and an optional hold-to-auto-repeat FSM for press mode.
// The per-channel repeat FSM state is visible as g_ch[i].rstate.
module debounce_tick_array #(
   parameter int N_CH            = 5,
   parameter int CNT_W           = 20,
   parameter int DEB_CYCLES      = 4,
   parameter int TICK_ON_RELEASE = 1,
   parameter int REPEAT_EN       = 0,
   parameter int HOLD_CYCLES     = 500000,
   parameter int REPEAT_CYCLES   = 100000
) (
   input  logic            clkr,
   input  logic            rstr_n,
   input  logic [N_CH-1:0] levelr,
   input  logic            en,
   output logic [N_CH-1:0] tickr,
   output logic [N_CH-1:0] stater,
   output logic [N_CH-1:0] holdr
);

   // Auto-repeat only makes sense when ticking on the press edge.
   localparam bit RPT = (REPEAT_EN != 0) && (TICK_ON_RELEASE == 0);
   // Level of the debounced transition that produces a plain tick.
   localparam logic TICK_LEVEL = (TICK_ON_RELEASE == 0);

   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   if (DEB_CYCLES < 1 || DEB_CYCLES >= (1 << CNT_W) ||
       HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W) ||
       REPEAT_CYCLES < 1 || REPEAT_CYCLES >= (1 << CNT_W)) begin : g_param_chk
      $error("debounce_tick_array: cycle parameter out of range for CNT_W");
   end

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      PRESSED   = 2'd1,
      REPEATING = 2'd2
   } rstate_t;

   logic [N_CH-1:0] s1;
   logic [N_CH-1:0] s2;

   // Two-flop synchroniser; only s2 is used by the rest of the logic.
   always_ff @(posedge clkr or negedge rstr_n) begin
      if (!rstr_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= levelr;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] dcnt;
      logic             st_q;
      logic             mism;
      logic             accept;
      logic             st_nxt;
      rstate_t          rstate;
      rstate_t          rstate_nxt;
      logic [CNT_W-1:0] rcnt;
      logic [CNT_W-1:0] rcnt_nxt;
      logic             tick_q;
      logic             tick_nxt;

      assign mism   = s2[i] ^ st_q;
      assign accept = mism && (dcnt == DEB_LAST);
      // Debounced level as it will be after this edge. The FSM uses it so
      // that a release wins over a repeat tick due on the same edge.
      assign st_nxt = accept ? s2[i] : st_q;

      // Stability counter: any cycle where the synchronised level matches the
      // debounced level restarts the count.
      always_ff @(posedge clkr or negedge rstr_n) begin
         if (!rstr_n) begin
            dcnt <= '0;
            st_q <= 1'b0;
         end else if (!mism) begin
            dcnt <= '0;
         end else if (accept) begin
            dcnt <= '0;
            st_q <= s2[i];
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end

      // Tick generation and the hold/repeat FSM: next state, counter and tick.
      always_comb begin
         rstate_nxt = rstate;
         rcnt_nxt   = rcnt;
         tick_nxt   = 1'b0;
         if (!RPT) begin
            rstate_nxt = RELEASED;
            rcnt_nxt   = '0;
            tick_nxt   = accept && (s2[i] == TICK_LEVEL);
         end else if (!st_nxt) begin
            rstate_nxt = RELEASED;
            rcnt_nxt   = '0;
         end else begin
            case (rstate)
               RELEASED: begin
                  tick_nxt   = accept;
                  rcnt_nxt   = '0;
                  rstate_nxt = PRESSED;
               end
               PRESSED: begin
                  if (!en) begin
                     rcnt_nxt = '0;
                  end else if (rcnt == HOLD_LAST) begin
                     tick_nxt   = 1'b1;
                     rcnt_nxt   = '0;
                     rstate_nxt = REPEATING;
                  end else begin
                     rcnt_nxt = rcnt + 1'b1;
                  end
               end
               REPEATING: begin
                  if (!en) begin
                     rcnt_nxt = '0;
                  end else if (rcnt == REPEAT_LAST) begin
                     tick_nxt = 1'b1;
                     rcnt_nxt = '0;
                  end else begin
                     rcnt_nxt = rcnt + 1'b1;
                  end
               end
               default: begin
                  rstate_nxt = RELEASED;
                  rcnt_nxt   = '0;
               end
            endcase
         end
         tick_nxt = tick_nxt && en;
      end

      // FSM state, repeat counter and registered tick.
      always_ff @(posedge clkr or negedge rstr_n) begin
         if (!rstr_n) begin
            rstate <= RELEASED;
            rcnt   <= '0;
            tick_q <= 1'b0;
         end else begin
            rstate <= rstate_nxt;
            rcnt   <= rcnt_nxt;
            tick_q <= tick_nxt;
         end
      end

      assign stater[i] = st_q;
      assign tickr[i]  = tick_q;
      assign holdr[i]  = (rstate == REPEATING);
   end

endmodule

// File: tb/tb_debounce_tick_array.sv
// Directed bench for debounce_tick_array.
// dut_a runs in release-tick mode. dut_b runs in press mode with auto-repeat
// (HOLD_CYCLES=10, REPEAT_CYCLES=3). Both use DEB_CYCLES=4.
// Edge numbering: edge 0 is the first rising edge that samples a new level.
// Outputs are sampled 1 ns after each rising edge.
module tb_debounce_tick_array;

   localparam int N = 5;

   logic         clkr   = 1'b0;
   logic         rstr_n = 1'b0;
   logic         en     = 1'b1;
   logic [N-1:0] lvl_a  = '0;
   logic [N-1:0] lvl_b  = '0;
   logic [N-1:0] tick_a, st_a, hold_a;
   logic [N-1:0] tick_b, st_b, hold_b;
   logic [N-1:0] et, es, eh;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clkr = ~clkr;

   debounce_tick_array #(
      .N_CH(N), .CNT_W(20), .DEB_CYCLES(4), .TICK_ON_RELEASE(1), .REPEAT_EN(0),
      .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
   ) dut_a (
      .clkr(clkr), .rstr_n(rstr_n), .levelr(lvl_a), .en(en),
      .tickr(tick_a), .stater(st_a), .holdr(hold_a)
   );

   debounce_tick_array #(
      .N_CH(N), .CNT_W(20), .DEB_CYCLES(4), .TICK_ON_RELEASE(0), .REPEAT_EN(1),
      .HOLD_CYCLES(10), .REPEAT_CYCLES(3)
   ) dut_b (
      .clkr(clkr), .rstr_n(rstr_n), .levelr(lvl_b), .en(en),
      .tickr(tick_b), .stater(st_b), .holdr(hold_b)
   );

   task automatic step();
      @(posedge clkr);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({tick_a, st_a, hold_a, tick_b, st_b, hold_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got=%b %b %b %b %b %b exp=all zero",
                  tick_a, st_a, hold_a, tick_b, st_b, hold_b);
      end
      step();
      rstr_n = 1'b1;
      for (int e = 0; e < 6; e++) begin
         step();
         n_checks++;
         if ({tick_a, st_a, hold_a, tick_b, st_b, hold_b} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset e=%0d got=%b %b %b %b %b %b exp=all zero",
                     e, tick_a, st_a, hold_a, tick_b, st_b, hold_b);
         end
      end
   endtask

   task automatic test_release_tick();
      lvl_a[0] = 1'b1;
      for (int e = 0; e <= 30; e++) begin
         step();
         et = '0; es = '0; eh = '0;
         et[0] = (e == 25);
         es[0] = (e >= 5) && (e < 25);
         n_checks++;
         if ({tick_a, st_a, hold_a} !== {et, es, eh}) begin
            n_fail++;
            $display("FAIL release_tick e=%0d got t=%b s=%b h=%b exp t=%b s=%b h=%b",
                     e, tick_a, st_a, hold_a, et, es, eh);
         end
         if (e == 19) lvl_a[0] = 1'b0;
      end
   endtask

   task automatic test_glitch();
      lvl_a[1] = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         step();
         n_checks++;
         if ({tick_a, st_a} !== '0) begin
            n_fail++;
            $display("FAIL glitch_3cyc e=%0d got t=%b s=%b exp t=00000 s=00000",
                     e, tick_a, st_a);
         end
         if (e == 2) lvl_a[1] = 1'b0;
      end
      lvl_a[1] = 1'b1;
      for (int e = 0; e <= 12; e++) begin
         step();
         et = '0; es = '0;
         es[1] = (e >= 5) && (e < 9);
         et[1] = (e == 9);
         n_checks++;
         if ({tick_a, st_a} !== {et, es}) begin
            n_fail++;
            $display("FAIL glitch_4cyc e=%0d got t=%b s=%b exp t=%b s=%b",
                     e, tick_a, st_a, et, es);
         end
         if (e == 3) lvl_a[1] = 1'b0;
      end
   endtask

   task automatic test_repeat();
      lvl_b[0] = 1'b1;
      for (int e = 0; e <= 45; e++) begin
         step();
         et = '0; es = '0; eh = '0;
         et[0] = (e == 5) || ((e >= 15) && (e < 36) && ((e - 15) % 3 == 0));
         es[0] = (e >= 5) && (e < 36);
         eh[0] = (e >= 15) && (e < 36);
         n_checks++;
         if ({tick_b, st_b, hold_b} !== {et, es, eh}) begin
            n_fail++;
            $display("FAIL repeat e=%0d got t=%b s=%b h=%b exp t=%b s=%b h=%b",
                     e, tick_b, st_b, hold_b, et, es, eh);
         end
         if (e == 30) lvl_b[0] = 1'b0;
      end
   endtask

   task automatic test_enable();
      en = 1'b0;
      lvl_b[2] = 1'b1;
      lvl_a[3] = 1'b1;
      for (int e = 0; e <= 40; e++) begin
         step();
         et = '0; es = '0; eh = '0;
         et[2] = (e >= 22) && (e < 36) && ((e - 22) % 3 == 0);
         es[2] = (e >= 5) && (e < 36);
         eh[2] = (e >= 22) && (e < 36);
         n_checks++;
         if ({tick_b, st_b, hold_b} !== {et, es, eh}) begin
            n_fail++;
            $display("FAIL enable_b e=%0d got t=%b s=%b h=%b exp t=%b s=%b h=%b",
                     e, tick_b, st_b, hold_b, et, es, eh);
         end
         es = '0;
         es[3] = (e >= 5) && (e < 11);
         n_checks++;
         if ({tick_a, st_a} !== {5'b00000, es}) begin
            n_fail++;
            $display("FAIL enable_a e=%0d got t=%b s=%b exp t=00000 s=%b",
                     e, tick_a, st_a, es);
         end
         if (e == 5) lvl_a[3] = 1'b0;
         if (e == 12) en = 1'b1;
         if (e == 30) lvl_b[2] = 1'b0;
      end
   endtask

   task automatic test_simultaneous();
      lvl_a = 5'b10001;
      lvl_b = 5'b10001;
      for (int e = 0; e <= 20; e++) begin
         step();
         es = ((e >= 5) && (e < 13)) ? 5'b10001 : 5'b00000;
         et = (e == 5) ? 5'b10001 : 5'b00000;
         n_checks++;
         if ({tick_b, st_b, hold_b} !== {et, es, 5'b00000}) begin
            n_fail++;
            $display("FAIL simul_press e=%0d got t=%b s=%b h=%b exp t=%b s=%b h=00000",
                     e, tick_b, st_b, hold_b, et, es);
         end
         et = (e == 13) ? 5'b10001 : 5'b00000;
         n_checks++;
         if ({tick_a, st_a} !== {et, es}) begin
            n_fail++;
            $display("FAIL simul_release e=%0d got t=%b s=%b exp t=%b s=%b",
                     e, tick_a, st_a, et, es);
         end
         if (e == 7) begin
            lvl_a = '0;
            lvl_b = '0;
         end
      end
   endtask

   task automatic test_async_reset();
      lvl_b[0] = 1'b1;
      for (int e = 0; e <= 21; e++) begin
         step();
         if (e == 21) begin
            n_checks++;
            if ({tick_b, st_b, hold_b} !== {5'b00001, 5'b00001, 5'b00001}) begin
               n_fail++;
               $display("FAIL pre_reset_repeating got t=%b s=%b h=%b exp t=00001 s=00001 h=00001",
                        tick_b, st_b, hold_b);
            end
         end
      end
      #2 rstr_n = 1'b0;
      #1;
      n_checks++;
      if ({tick_a, st_a, hold_a, tick_b, st_b, hold_b} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got=%b %b %b %b %b %b exp=all zero",
                  tick_a, st_a, hold_a, tick_b, st_b, hold_b);
      end
      #1 rstr_n = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         step();
         et = '0; es = '0;
         et[0] = (e == 5);
         es[0] = (e >= 5);
         n_checks++;
         if ({tick_b, st_b, hold_b} !== {et, es, 5'b00000}) begin
            n_fail++;
            $display("FAIL post_reset_press e=%0d got t=%b s=%b h=%b exp t=%b s=%b h=00000",
                     e, tick_b, st_b, hold_b, et, es);
         end
      end
      lvl_b[0] = 1'b0;
      for (int e = 0; e < 15; e++) step();
      n_checks++;
      if ({st_a, hold_a, st_b, hold_b} !== '0) begin
         n_fail++;
         $display("FAIL final_idle got=%b %b %b %b exp=all zero", st_a, hold_a, st_b, hold_b);
      end
   endtask

   initial begin
      test_reset();
      test_release_tick();
      test_glitch();
      test_repeat();
      test_enable();
      test_simultaneous();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
